// File: rtl/alu_cmd_sequencer.sv
// Command FIFO feeding an external ALU one command at a time, then holding
// each ALU result on a valid/ready output until downstream accepts it.
module alu_cmd_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ALU_LAT    = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic        [1:0]             cmd_opcode,
    input  logic signed [3:0]             cmd_a,
    input  logic signed [3:0]             cmd_b,
    output logic        [1:0]             alu_opcode,
    output logic signed [3:0]             alu_a,
    output logic signed [3:0]             alu_b,
    input  logic signed [4:0]             alu_c,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic signed [4:0]             res_data,
    output logic        [1:0]             res_opcode,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state, next_state;

    logic [9:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [LW-1:0]       lat_cnt;
    logic [9:0]          head;
    logic [1:0]          head_op;
    logic signed [3:0]   head_a, head_b;
    logic                push, pop, capture, res_done;

    // Ready comes from the cycle-start count only, so a same-cycle pop never frees a slot.
    assign cmd_ready = !reset && (fifo_count < CW'(FIFO_DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE) || (fifo_count != '0);

    assign head    = mem[rd_ptr];
    assign head_op = head[9:8];
    assign head_a  = head[7:4];
    assign head_b  = head[3:0];

    // Storage has no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_opcode, cmd_a, cmd_b};
        end
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        capture    = 1'b0;
        res_done   = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop        = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt == LW'(1)) begin
                    capture    = 1'b1;
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    res_done   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            lat_cnt    <= '0;
            alu_opcode <= 2'b00;
            alu_a      <= '0;
            alu_b      <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_opcode <= 2'b00;
        end else begin
            state <= next_state;

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end

            // Issue: operands stay on the ALU bus until the next pop.
            if (pop) begin
                rd_ptr     <= rd_ptr + AW'(1);
                alu_opcode <= head_op;
                alu_a      <= head_a;
                alu_b      <= head_b;
                lat_cnt    <= LW'(ALU_LAT);
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt - LW'(1);
            end

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase

            if (capture) begin
                res_valid  <= 1'b1;
                res_data   <= alu_c;
                res_opcode <= alu_opcode;
            end else if (res_done) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU on the alu_* bus.
module tb_alu_cmd_sequencer;

    logic                clk = 1'b0;
    logic                reset;
    logic                cmd_valid;
    logic                cmd_ready;
    logic        [1:0]   cmd_opcode;
    logic signed [3:0]   cmd_a, cmd_b;
    logic        [1:0]   alu_opcode;
    logic signed [3:0]   alu_a, alu_b;
    logic signed [4:0]   alu_c;
    logic                res_valid;
    logic                res_ready;
    logic signed [4:0]   res_data;
    logic        [1:0]   res_opcode;
    logic        [2:0]   fifo_count;
    logic                busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.FIFO_DEPTH(4), .ALU_LAT(1)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_opcode(res_opcode),
        .fifo_count(fifo_count), .busy(busy)
    );

    function automatic logic signed [4:0] alu_ref(input logic [1:0] op,
                                                   input logic [3:0] a,
                                                   input logic [3:0] b);
        case (op)
            2'b00:   return {a[3], a} + {b[3], b};
            2'b01:   return {a[3], a} - {b[3], b};
            2'b10:   return ~{a[3], a};
            default: return {4'b0000, |b};
        endcase
    endfunction

    // ALU with one cycle of latency: result settles well within a cycle.
    always_comb alu_c = alu_ref(alu_opcode, alu_a, alu_b);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
    endtask

    task automatic collect(input string tag, input int exp_data, input int exp_op);
        int n = 0;
        while (!res_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, res_valid, 1);
        chk({tag, "_data"}, res_data, exp_data);
        chk({tag, "_op"}, res_opcode, exp_op);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk({tag, "_clr"}, res_valid, 0);
    endtask

    logic [1:0]        wop [10];
    logic [3:0]        wa  [10];
    logic [3:0]        wb  [10];
    logic signed [4:0] wexp[10];

    initial begin
        int accepted;
        int sent, got, cyc;
        logic acc;

        reset = 1'b1; cmd_valid = 1'b1; cmd_opcode = 2'b00;
        cmd_a = 4'd1; cmd_b = 4'd1; res_ready = 1'b0;
        step();
        chk("rst_ready", cmd_ready, 0);
        step();
        chk("rst_count", fifo_count, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_data", res_data, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_busy", busy, 0);
        cmd_valid = 1'b0;
        reset = 1'b0;
        step();

        // Single add 3+2
        res_ready = 1'b1;
        drive(2'b00, 4'd3, 4'd2);
        step();
        cmd_valid = 1'b0;
        chk("add_count", fifo_count, 1);
        step();
        chk("add_alu_op", alu_opcode, 0);
        chk("add_alu_a", alu_a, 3);
        chk("add_alu_b", alu_b, 2);
        chk("add_early", res_valid, 0);
        step();
        chk("add_valid", res_valid, 1);
        chk("add_data", res_data, 5);
        chk("add_op", res_opcode, 0);
        step();
        chk("add_clr", res_valid, 0);
        chk("add_idle", busy, 0);
        res_ready = 1'b0;

        // Mixed ops
        drive(2'b01, 4'b1000, 4'd7); step();
        drive(2'b10, 4'd5, 4'd0);    step();
        drive(2'b11, 4'd0, 4'd0);    step();
        drive(2'b11, 4'd0, 4'b1111); step();
        cmd_valid = 1'b0;
        collect("sub", -15, 1);
        collect("nota", -6, 2);
        collect("orb0", 0, 3);
        collect("orb1", 1, 3);

        // Backpressure from empty: operands i+1 so result of cmd i is i+1
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            drive(2'b00, 4'(accepted), 4'd1);
            acc = cmd_ready;
            step();
            if (acc) accepted++;
        end
        chk("bp_accepted", accepted, 5);
        chk("bp_ready", cmd_ready, 0);
        chk("bp_count", fifo_count, 4);
        chk("bp_hold_valid", res_valid, 1);
        chk("bp_hold_data0", res_data, 1);
        step();
        step();
        chk("bp_hold_data1", res_data, 1);
        chk("bp_hold_count", fifo_count, 4);

        // Full boundary: release, then the pop cycle sees a full FIFO with cmd_valid high
        drive(2'b00, 4'd7, 4'd0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("full_released", res_valid, 0);
        chk("full_pre_count", fifo_count, 4);
        step();
        cmd_valid = 1'b0;
        chk("full_count", fifo_count, 3);
        chk("full_ready", cmd_ready, 1);
        collect("bp_r2", 2, 0);
        collect("bp_r3", 3, 0);
        collect("bp_r4", 4, 0);
        collect("bp_r5", 5, 0);
        step();
        chk("bp_empty", fifo_count, 0);
        chk("bp_not_busy", busy, 0);

        // Reset while in WAIT with two entries queued
        drive(2'b00, 4'd1, 4'd1); step();
        drive(2'b00, 4'd2, 4'd2); step();
        drive(2'b01, 4'd3, 4'd1); step();
        drive(2'b00, 4'd4, 4'd4); step();
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        step();
        chk("mid_wait_count", fifo_count, 2);
        chk("mid_wait_alu_a", alu_a, 2);
        chk("mid_wait_valid", res_valid, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_alu_op", alu_opcode, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_b", alu_b, 0);
        chk("mid_rst_busy", busy, 0);
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("mid_no_stale", res_valid, 0);
        end

        // Wrap-around stream with random operands
        for (int i = 0; i < 10; i++) begin
            wop[i]  = 2'($urandom_range(0, 3));
            wa[i]   = 4'($urandom_range(0, 15));
            wb[i]   = 4'($urandom_range(0, 15));
            wexp[i] = alu_ref(wop[i], wa[i], wb[i]);
        end
        sent = 0; got = 0; cyc = 0;
        while (got < 10 && cyc < 300) begin
            if (sent < 10) drive(wop[sent], wa[sent], wb[sent]);
            else cmd_valid = 1'b0;
            acc = cmd_valid && cmd_ready;
            step();
            cyc++;
            if (acc) sent++;
            if (res_valid) begin
                chk("wrap_data", res_data, wexp[got]);
                chk("wrap_op", res_opcode, wop[got]);
                got++;
            end
        end
        cmd_valid = 1'b0;
        chk("wrap_results", got, 10);
        chk("wrap_sent", sent, 10);
        step();
        chk("wrap_extra", res_valid, 0);
        chk("wrap_empty", fifo_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
